// File: rtl/div_pkg.sv
`default_nettype none
// =============================================================================
// Package : div_pkg
// Brief   : Shared widths, FSM encoding and exception result constants for div_module
// Rev     : 1.0  initial release
// =============================================================================
package div_pkg;

  localparam int DIV_DIVIDEND_W = 32;
  localparam int DIV_DIVISOR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Results forced alongside data_exception
  localparam logic [DIV_DIVIDEND_W-1:0] DIV_ZERO_RESULT = '0;
  localparam logic [DIV_DIVIDEND_W-1:0] DIV_OVF_RESULT  = {1'b1, {(DIV_DIVIDEND_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// =============================================================================
// Module : div_step
// Brief  : One combinational restoring shift / trial-subtract / quotient-bit step
// Rev    : 1.0  initial release
// =============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic [DIVIDEND_W-1:0] quo_i,
  input  logic [DIVISOR_W:0]    rem_i,
  input  logic [DIVISOR_W:0]    dvs_i,
  output logic [DIVIDEND_W-1:0] quo_o,
  output logic [DIVISOR_W:0]    rem_o
);

  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W+1:0] diff;
  logic                 fits;
  // Partial remainder stays below |B| <= 2^(DIVISOR_W-1), so its MSB is always zero
  logic                 unused_rem_msb;

  assign unused_rem_msb = rem_i[DIVISOR_W];

  always_comb begin
    trial = {rem_i[DIVISOR_W-1:0], quo_i[DIVIDEND_W-1]};
    diff  = {1'b0, trial} - {1'b0, dvs_i};
    fits  = ~diff[DIVISOR_W+1];
    rem_o = fits ? diff[DIVISOR_W:0] : trial;
    quo_o = {quo_i[DIVIDEND_W-2:0], fits};
  end

endmodule
`default_nettype wire

// File: rtl/div_module.sv
`default_nettype none
// =============================================================================
// Module : div_module
// Brief  : Signed restoring divider, one quotient bit per cycle, with
//          divide-by-zero and MIN/-1 overflow flagging
// Rev    : 1.0  initial release
// =============================================================================
module div_module
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DIVIDEND_W-1:0] data_operandA,
  input  logic [DIVISOR_W-1:0]  data_operandB,
  input  logic                  ctrl_DIV,
  output logic [DIVIDEND_W-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_inputRDY,
  output logic                  data_resultRDY
);

  localparam int                    CNT_W    = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] A_MIN    = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W:0]    dvs_q;
  logic                  neg_q;
  logic                  ovf_q;
  logic [DIVIDEND_W-1:0] result_q;
  logic                  exc_q;
  logic                  rdy_q;

  logic                  a_neg;
  logic                  b_neg;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W:0]    b_ext;
  logic [DIVISOR_W:0]    b_mag;
  logic                  b_zero;
  logic                  ovf_case;
  logic [DIVIDEND_W-1:0] quo_d;
  logic [DIVISOR_W:0]    rem_d;
  logic [DIVIDEND_W-1:0] quo_fix;

  assign a_neg    = data_operandA[DIVIDEND_W-1];
  assign b_neg    = data_operandB[DIVISOR_W-1];
  assign a_mag    = a_neg ? -data_operandA : data_operandA;
  assign b_ext    = {b_neg, data_operandB};
  assign b_mag    = b_neg ? -b_ext : b_ext;
  assign b_zero   = (data_operandB == '0);
  assign ovf_case = (data_operandA == A_MIN) && (data_operandB == '1);
  assign quo_fix  = neg_q ? -quo_d : quo_d;

  div_step #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W)
  ) u_step (
    .quo_i (quo_q),
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .quo_o (quo_d),
    .rem_o (rem_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ctrl_DIV) begin
            quo_q <= a_mag;
            rem_q <= '0;
            dvs_q <= b_mag;
            neg_q <= a_neg ^ b_neg;
            ovf_q <= ovf_case;
            cnt_q <= '0;
            // A zero divisor skips the iteration entirely
            if (b_zero) begin
              state_q  <= ST_DONE;
              result_q <= DIVIDEND_W'(DIV_ZERO_RESULT);
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q  <= ST_DONE;
            result_q <= ovf_q ? DIVIDEND_W'(DIV_OVF_RESULT) : quo_fix;
            exc_q    <= ovf_q;
            rdy_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_inputRDY  = (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_div_module.sv
`default_nettype none
// =============================================================================
// Module : tb_div_module
// Brief  : Directed self-checking bench for div_module
// Rev    : 1.0  initial release
// =============================================================================
module tb_div_module;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] prev_res = '0;
  logic        prev_exc = 1'b0;

  div_module dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents operands with ctrl_DIV for exactly one rising edge (E0)
  task automatic start(input logic [31:0] a, input logic [15:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV      = 1'b0;
  endtask

  // k0 = number of edges already elapsed since E0; lat = edge index after which resultRDY is seen
  task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                           input int exp_lat, input int k0, input bit rel);
    int k;
    k = k0;
    if (exp_lat > k0) begin
      check({tag, "_busy"},     32'(data_inputRDY), 32'd0);
      check({tag, "_hold_res"}, data_result, prev_res);
      check({tag, "_hold_exc"}, 32'(data_exception), 32'(prev_exc));
    end
    while (!data_resultRDY && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_result"},  data_result, exp_res);
    check({tag, "_exc"},     32'(data_exception), 32'(exp_exc));
    check({tag, "_inrdy"},   32'(data_inputRDY), 32'd1);
    prev_res = exp_res;
    prev_exc = exp_exc;
    if (rel) begin
      tick();
      check({tag, "_pulse_end"}, 32'(data_resultRDY), 32'd0);
      check({tag, "_idle_rdy"},  32'(data_inputRDY), 32'd1);
      check({tag, "_held"},      data_result, exp_res);
    end
  endtask

  initial begin
    int seen;
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", data_result, 32'd0);
    check("rst_exc",    32'(data_exception), 32'd0);
    check("rst_rdy",    32'(data_resultRDY), 32'd0);
    check("rst_inrdy",  32'(data_inputRDY), 32'd1);

    // Accept on the very first edge after reset release
    reset_n = 1'b1;
    start(32'd100, 16'd7);
    finish_op("pos_pos", 32'd14, 1'b0, 32, 0, 1'b1);

    start(32'hFFFF_FF9C, 16'd7);
    finish_op("neg_pos", 32'hFFFF_FFF2, 1'b0, 32, 0, 1'b1);
    start(32'd100, 16'hFFF9);
    finish_op("pos_neg", 32'hFFFF_FFF2, 1'b0, 32, 0, 1'b1);
    start(32'hFFFF_FF9C, 16'hFFF9);
    finish_op("neg_neg", 32'd14, 1'b0, 32, 0, 1'b1);

    start(32'd12345, 16'd0);
    finish_op("div0", 32'd0, 1'b1, 0, 0, 1'b1);

    start(32'h8000_0000, 16'hFFFF);
    finish_op("ovf", 32'h8000_0000, 1'b1, 32, 0, 1'b1);

    start(32'h7FFF_FFFF, 16'h8000);
    finish_op("maxdvs", 32'hFFFF_0001, 1'b0, 32, 0, 1'b1);

    // ctrl_DIV at E10 must be ignored; then a DONE-cycle accept runs back-to-back
    start(32'd1000, 16'd10);
    repeat (9) tick();
    data_operandA = 32'd50;
    data_operandB = 16'd5;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV      = 1'b0;
    finish_op("ignore", 32'd100, 1'b0, 32, 10, 1'b0);
    start(32'd50, 16'd5);
    finish_op("b2b", 32'd10, 1'b0, 32, 0, 1'b1);

    // Reset cut mid-run at E15
    start(32'd1000, 16'd3);
    repeat (15) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc",    32'(data_exception), 32'd0);
    check("midrst_rdy",    32'(data_resultRDY), 32'd0);
    check("midrst_inrdy",  32'(data_inputRDY), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (data_resultRDY) seen++;
    end
    check("midrst_no_pulse", 32'(seen), 32'd0);
    check("midrst_idle",     32'(data_inputRDY), 32'd1);
    prev_res = '0;
    prev_exc = 1'b0;
    start(32'd1000, 16'd3);
    finish_op("after_rst", 32'd333, 1'b0, 32, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
